// File: rtl/id_issue_stage_pkg.sv
// Shared decode definitions for the decode/issue stage: ALU op codes,
// instruction field positions and the field decode helper.
package id_issue_stage_pkg;

    localparam int RIDX_W = 4;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 27;
    localparam int I_BIT   = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS1_MSB = 21;
    localparam int RS1_LSB = 18;
    localparam int RS2_MSB = 17;
    localparam int RS2_LSB = 14;
    localparam int IMM_MSB = 15;

    localparam logic [4:0] ALUOP_ADD  = 5'd0;
    localparam logic [4:0] ALUOP_SUB  = 5'd1;
    localparam logic [4:0] ALUOP_MUL  = 5'd2;
    localparam logic [4:0] ALUOP_DIV  = 5'd3;
    localparam logic [4:0] ALUOP_AND  = 5'd4;
    localparam logic [4:0] ALUOP_OR   = 5'd5;
    localparam logic [4:0] ALUOP_NOT  = 5'd6;
    localparam logic [4:0] ALUOP_XOR  = 5'd7;
    localparam logic [4:0] ALUOP_SHL  = 5'd8;
    localparam logic [4:0] ALUOP_SHR  = 5'd9;
    localparam logic [4:0] ALUOP_ASR  = 5'd10;
    localparam logic [4:0] ALUOP_MOV  = 5'd11;
    localparam logic [4:0] ALUOP_MOVL = 5'd12;
    localparam logic [4:0] ALUOP_MOVH = 5'd13;
    localparam logic [4:0] OP_NOP     = 5'd31;

    typedef struct packed {
        logic [4:0]        op;
        logic              imm;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic [15:0]       imm16;
        logic              is_alu;
        logic              use1;
        logic              use2;
        logic              we;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d.op     = inst[OP_MSB:OP_LSB];
        d.imm    = inst[I_BIT];
        d.rd     = inst[RD_MSB:RD_LSB];
        d.rs1    = inst[RS1_MSB:RS1_LSB];
        d.rs2    = inst[RS2_MSB:RS2_LSB];
        d.imm16  = inst[IMM_MSB:0];
        d.is_alu = (d.op <= ALUOP_MOVH);
        // MOV with an immediate takes its value from imm16, not rs1
        d.use1   = d.is_alu && !(d.op == ALUOP_NOT || d.op == ALUOP_MOVL ||
                                 d.op == ALUOP_MOVH || (d.op == ALUOP_MOV && d.imm));
        d.use2   = d.is_alu && !d.imm &&
                   !(d.op == ALUOP_MOV || d.op == ALUOP_MOVL || d.op == ALUOP_MOVH);
        d.we     = d.is_alu && (d.rd != '0);
        return d;
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback (set wins), wiped by flush. Register 0 never busy.
module id_scoreboard
    import id_issue_stage_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              set_en,
    input  logic [RIDX_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [RIDX_W-1:0] clr_idx,
    input  logic [RIDX_W-1:0] q1_idx,
    input  logic [RIDX_W-1:0] q2_idx,
    output logic              q1_busy,
    output logic              q2_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_idx] = 1'b0;
        if (set_en)
            busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign q1_busy = busy[q1_idx];
    assign q2_busy = busy[q2_idx];

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage feeding the ALU: decode, operand select, RAW stall via
// scoreboard, one registered output slot. ID_PERF_EN adds perf counters.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic              flush,
    output logic [RIDX_W-1:0] rf_raddr1,
    output logic [RIDX_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              wb_en,
    input  logic [RIDX_W-1:0] wb_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_val1,
    output logic [XLEN-1:0]   out_val2,
    output logic [4:0]        out_aluop,
    output logic              out_is_alu_op,
    output logic [RIDX_W-1:0] out_rd,
`ifdef ID_PERF_EN
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_stalls,
`endif
    output logic              out_we
);

    dec_t            dec;
    logic [XLEN-1:0] src1, src2, imm_sx, imm_zx, imm_hi;
    logic [XLEN-1:0] val1, val2;
    logic            busy1, busy2, hazard, accept;

    assign dec       = decode(in_inst);
    assign rf_raddr1 = dec.rs1;
    assign rf_raddr2 = dec.rs2;

    assign src1   = (dec.rs1 == '0) ? '0 : rf_rdata1;
    assign src2   = (dec.rs2 == '0) ? '0 : rf_rdata2;
    assign imm_sx = {{(XLEN-16){dec.imm16[15]}}, dec.imm16};
    assign imm_zx = {{(XLEN-16){1'b0}}, dec.imm16};
    assign imm_hi = {dec.imm16, {(XLEN-16){1'b0}}};

    always_comb begin
        val1 = src1;
        if (dec.op == ALUOP_MOV && dec.imm)
            val1 = imm_sx;
        val2 = src2;
        if (dec.imm) begin
            if (dec.op == ALUOP_MOVL)
                val2 = imm_zx;
            else if (dec.op == ALUOP_MOVH)
                val2 = imm_hi;
            else
                val2 = imm_sx;
        end
    end

    id_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .set_en  (accept && dec.we),
        .set_idx (dec.rd),
        .clr_en  (wb_en),
        .clr_idx (wb_rd),
        .q1_idx  (dec.rs1),
        .q2_idx  (dec.rs2),
        .q1_busy (busy1),
        .q2_busy (busy2)
    );

    // Writeback clears land in the scoreboard and RF on the same edge,
    // so the hazard check only ever sees registered busy state.
    assign hazard   = (dec.use1 && busy1) || (dec.use2 && busy2);
    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_val1      <= '0;
            out_val2      <= '0;
            out_aluop     <= '0;
            out_is_alu_op <= 1'b0;
            out_rd        <= '0;
            out_we        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_val1      <= val1;
            out_val2      <= val2;
            out_aluop     <= dec.op;
            out_is_alu_op <= dec.is_alu;
            out_rd        <= dec.rd;
            out_we        <= dec.we;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ID_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stalls <= '0;
        end else if (flush) begin
            perf_issued <= '0;
            perf_stalls <= '0;
        end else begin
            if (accept)
                perf_issued <= perf_issued + 32'd1;
            if (in_valid && !in_ready)
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule
